// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_param deserialiser.
package sipo_pkg;

  typedef enum logic {
    SHIFT,
    FULL
  } state_e;

  localparam int unsigned WIDTH_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT = 16;

  // Bits needed to count 0..frame_bits inclusive.
  function automatic int unsigned cnt_w(int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register, bit counter and (with SIPO_PARITY_EN) parity accumulator for sipo_param.
// frame_done_o pulses combinationally on acceptance of the last bit of a frame.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
`ifdef SIPO_PARITY_EN
  parameter bit          PARITY_ODD = 1'b1,
`endif
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             accept_i,
  input  logic             bit_i,
  output logic             frame_done_o,
`ifdef SIPO_PARITY_EN
  output logic             perr_d_o,
  output logic             perr_q_o,
`endif
  output logic [WIDTH-1:0] word_d_o,
  output logic [WIDTH-1:0] word_q_o
);

`ifdef SIPO_PARITY_EN
  localparam int unsigned FrameBits = WIDTH + 1;
`else
  localparam int unsigned FrameBits = WIDTH;
`endif
  localparam int unsigned BitCntW = cnt_w(FrameBits);

  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               last_bit;
  logic               data_bit;

  assign last_bit     = (bit_cnt_q == BitCntW'(FrameBits - 1));
  assign frame_done_o = accept_i && last_bit;
  assign word_d_o     = shift_d;
  assign word_q_o     = shift_q;

`ifdef SIPO_PARITY_EN
  // The trailing parity bit is checked, never shifted into the word.
  assign data_bit = accept_i && !last_bit;
`else
  assign data_bit = accept_i;
`endif

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (clr_i) begin
      bit_cnt_d = '0;
    end else if (accept_i) begin
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + BitCntW'(1);
    end
    if (data_bit && !clr_i) begin
      if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], bit_i};
      else           shift_d = {bit_i, shift_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

`ifdef SIPO_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
  logic par_total;

  assign par_total = par_q ^ bit_i;
  assign perr_d_o  = perr_d;
  assign perr_q_o  = perr_q;

  always_comb begin
    par_d  = par_q;
    perr_d = perr_q;
    if (clr_i) begin
      par_d = 1'b0;
    end else if (accept_i) begin
      if (last_bit) begin
        par_d  = 1'b0;
        // Odd sense expects an odd total count of ones including the parity bit.
        perr_d = par_total ^ PARITY_ODD;
      end else begin
        par_d = par_total;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
`endif

endmodule

// File: rtl/sipo_param.sv
// Parametrised double-buffered serial-in/parallel-out deserialiser with valid/ready on both sides.
// Define SIPO_PARITY_EN to append a parity bit to each frame and expose p_perr_o.
module sipo_param
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEFAULT,
  parameter bit          MSB_FIRST  = 1'b1,
`ifdef SIPO_PARITY_EN
  parameter bit          PARITY_ODD = 1'b1,
`endif
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             s_valid_i,
  input  logic             s_data_i,
  output logic             s_ready_o,
  output logic             p_valid_o,
  output logic [WIDTH-1:0] p_data_o,
  input  logic             p_ready_i,
`ifdef SIPO_PARITY_EN
  output logic             p_perr_o,
`endif
  output logic [CNT_W-1:0] word_cnt_o
);

  state_e             state_q, state_d;
  logic               p_valid_q, p_valid_d;
  logic [WIDTH-1:0]   p_data_q, p_data_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               in_shift;
  logic               clr_eff;
  logic               accept;
  logic               deliver;
  logic               frame_done;
  logic [WIDTH-1:0]   core_word_d, core_word_q;

  // s_ready depends on state only, so no combinational path from either handshake.
  assign in_shift = (state_q == SHIFT);
  assign clr_eff  = clr_i && in_shift;
  assign accept   = s_valid_i && in_shift && !clr_i;
  assign deliver  = p_valid_q && p_ready_i;

  assign s_ready_o  = in_shift;
  assign p_valid_o  = p_valid_q;
  assign p_data_o   = p_data_q;
  assign word_cnt_o = word_cnt_q;

`ifdef SIPO_PARITY_EN
  logic core_perr_d, core_perr_q;
  logic p_perr_q, p_perr_d;
  assign p_perr_o = p_perr_q;
`endif

  sipo_shift_core #(
    .WIDTH      (WIDTH),
`ifdef SIPO_PARITY_EN
    .PARITY_ODD (PARITY_ODD),
`endif
    .MSB_FIRST  (MSB_FIRST)
  ) u_core (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (clr_eff),
    .accept_i     (accept),
    .bit_i        (s_data_i),
    .frame_done_o (frame_done),
`ifdef SIPO_PARITY_EN
    .perr_d_o     (core_perr_d),
    .perr_q_o     (core_perr_q),
`endif
    .word_d_o     (core_word_d),
    .word_q_o     (core_word_q)
  );

  always_comb begin
    state_d    = state_q;
    p_valid_d  = p_valid_q;
    p_data_d   = p_data_q;
    word_cnt_d = deliver ? word_cnt_q + CNT_W'(1) : word_cnt_q;
`ifdef SIPO_PARITY_EN
    p_perr_d   = p_perr_q;
`endif
    if (deliver) p_valid_d = 1'b0;
    unique case (state_q)
      SHIFT: begin
        if (frame_done) begin
          if (!p_valid_q || p_ready_i) begin
            p_valid_d = 1'b1;
            p_data_d  = core_word_d;
`ifdef SIPO_PARITY_EN
            p_perr_d  = core_perr_d;
`endif
          end else begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (deliver) begin
          p_valid_d = 1'b1;
          p_data_d  = core_word_q;
`ifdef SIPO_PARITY_EN
          p_perr_d  = core_perr_q;
`endif
          state_d   = SHIFT;
        end
      end
      default: state_d = SHIFT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SHIFT;
      p_valid_q  <= 1'b0;
      p_data_q   <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      p_valid_q  <= p_valid_d;
      p_data_q   <= p_data_d;
      word_cnt_q <= word_cnt_d;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) p_perr_q <= 1'b0;
    else         p_perr_q <= p_perr_d;
  end
`endif

endmodule
